id_ex_stage: RTL and testbench

Pipeline register and operand-selection stage between decode and execute in the 5-stage RV32I core. Captures decoded operands and control each cycle and drives the execute ALU's `a`, `b` and 4-bit `alucontrol` inputs. Owns load-use hazard detection (stall/bubble) and the operand forwarding network from EX/MEM and MEM/WB. Accepts a branch flush that kills the instruction entering EX.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/fwd_sel.sv | 44 ++++
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants for the RV32I pipeline slice.
//   XLEN / REGW       : datapath and register-index widths
//   alu_op_e          : 4-bit ALU operation codes driven to the execute ALU
//   fwd_sel_e         : operand source chosen by the forwarding network
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: operand forwarding mux for one source register.
//   rs_idx / rf_data            : registered source index and register-file value
//   exmem_* / memwb_*           : writeback enable, destination and value of later stages
//   fwd_data                    : newest available value of rs_idx
// Index 0 never forwards; the EX/MEM value is newer than MEM/WB so it wins.
module fwd_sel #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic [REGW-1:0] rs_idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_regwrite,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] fwd_data
);
  import rv32i_pkg::*;

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (rs_idx != '0) begin
      if (exmem_regwrite && (exmem_rd == rs_idx)) begin
        sel = FWD_EXMEM;
      end else if (memwb_regwrite && (memwb_rd == rs_idx)) begin
        sel = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    fwd_data = rf_data;
    case (sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_data;
      default:   fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand selection, load-use
// hazard detection and operand forwarding.
//   Inputs : id_* decoded instruction, flush (taken branch in EX),
//            exmem_*/memwb_* writeback triplets of later stages.
//   Outputs: id_stall (combinational), ex_* registered instruction with
//            forwarded ALU operands a/b and store data.
// Build option: define ID_EX_FWD_EN to enable the forwarding network; when
// undefined, id_stall also covers RAW hazards against EX and EX/MEM.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [3:0]      id_alucontrol,
  input  logic            id_asel_pc,
  input  logic            id_bsel_imm,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            flush,
  input  logic            exmem_regwrite,
  input  logic            memwb_regwrite,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_data,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alucontrol,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg
);
  import rv32i_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rd;
    logic [3:0]      alucontrol;
    logic            asel_pc;
    logic            bsel_imm;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
  } ex_reg_t;

  ex_reg_t         ex_q, ex_d, bubble;
  logic            load_use, raw_hazard, hazard;
  logic            fwd_exmem_we, fwd_memwb_we;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    bubble            = '0;
    bubble.alucontrol = ALU_ADD;
  end

  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
               ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
`ifdef ID_EX_FWD_EN
    raw_hazard   = 1'b0;
    fwd_exmem_we = exmem_regwrite;
    fwd_memwb_we = memwb_regwrite;
`else
    // Without forwarding, any pending write to a source in EX or EX/MEM must
    // drain first; WB is covered by the write-before-read register file.
    raw_hazard = id_valid && (
                   (ex_q.valid && ex_q.regwrite && (ex_q.rd != '0) &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2))) ||
                   (exmem_regwrite && (exmem_rd != '0) &&
                    ((exmem_rd == id_rs1) || (exmem_rd == id_rs2))));
    fwd_exmem_we = 1'b0;
    fwd_memwb_we = 1'b0;
`endif
    hazard   = load_use || raw_hazard;
    id_stall = hazard && !flush;
  end

`ifndef ID_EX_FWD_EN
  logic unused_memwb_regwrite;
  assign unused_memwb_regwrite = memwb_regwrite;
`endif

  always_comb begin
    ex_d = bubble;
    if (!(flush || hazard)) begin
      ex_d.valid      = id_valid;
      ex_d.pc         = id_pc;
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
      ex_d.rs1_data   = id_rs1_data;
      ex_d.rs2_data   = id_rs2_data;
      ex_d.imm        = id_imm;
      ex_d.rd         = id_rd;
      ex_d.alucontrol = id_alucontrol;
      ex_d.asel_pc    = id_asel_pc;
      ex_d.bsel_imm   = id_bsel_imm;
      ex_d.regwrite   = id_regwrite;
      ex_d.memread    = id_memread;
      ex_d.memwrite   = id_memwrite;
      ex_d.memtoreg   = id_memtoreg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= bubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_sel #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .rs_idx         (ex_q.rs1),
    .rf_data        (ex_q.rs1_data),
    .exmem_regwrite (fwd_exmem_we),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (fwd_memwb_we),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .fwd_data       (fwd_rs1)
  );

  fwd_sel #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .rs_idx         (ex_q.rs2),
    .rf_data        (ex_q.rs2_data),
    .exmem_regwrite (fwd_exmem_we),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (fwd_memwb_we),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .fwd_data       (fwd_rs2)
  );

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_alucontrol = ex_q.alucontrol;
  assign ex_a          = ex_q.asel_pc  ? ex_q.pc  : fwd_rs1;
  assign ex_b          = ex_q.bsel_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_regwrite   = ex_q.valid && ex_q.regwrite;
  assign ex_memread    = ex_q.valid && ex_q.memread;
  assign ex_memwrite   = ex_q.valid && ex_q.memwrite;
  assign ex_memtoreg   = ex_q.valid && ex_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus randomized run against a
// behavioural model of the ID/EX stage. Honors ID_EX_FWD_EN like the RTL.
module tb_id_ex_stage;
  import rv32i_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        rst, flush, idv;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        asel, bsel, rw, mr, mw, mt;
    logic        exrw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbrw;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
  } in_t;

  typedef struct packed {
    logic        stall, valid;
    logic [31:0] a, b, sd;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, mr, mw, mt;
  } exp_t;

  typedef struct packed {
    logic chk;
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  in_t         cur = '0;
  logic        id_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alucontrol;
  logic [4:0]  ex_rd;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // model: the instruction currently sitting in EX
  logic mv = 1'b0;
  in_t  mf = '0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk            (clk),
    .rst            (cur.rst),
    .id_valid       (cur.idv),
    .id_pc          (cur.pc),
    .id_rs1_data    (cur.d1),
    .id_rs2_data    (cur.d2),
    .id_imm         (cur.imm),
    .id_rs1         (cur.rs1),
    .id_rs2         (cur.rs2),
    .id_rd          (cur.rd),
    .id_alucontrol  (cur.alu),
    .id_asel_pc     (cur.asel),
    .id_bsel_imm    (cur.bsel),
    .id_regwrite    (cur.rw),
    .id_memread     (cur.mr),
    .id_memwrite    (cur.mw),
    .id_memtoreg    (cur.mt),
    .flush          (cur.flush),
    .exmem_regwrite (cur.exrw),
    .memwb_regwrite (cur.wbrw),
    .exmem_rd       (cur.exrd),
    .memwb_rd       (cur.wbrd),
    .exmem_result   (cur.exres),
    .memwb_data     (cur.wbdata),
    .id_stall       (id_stall),
    .ex_valid       (ex_valid),
    .ex_a           (ex_a),
    .ex_b           (ex_b),
    .ex_alucontrol  (ex_alucontrol),
    .ex_store_data  (ex_store_data),
    .ex_pc          (ex_pc),
    .ex_rd          (ex_rd),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".id_stall"},  32'(id_stall),      32'(e.stall));
    chk({tag, ".ex_valid"},  32'(ex_valid),      32'(e.valid));
    chk({tag, ".ex_a"},      ex_a,               e.a);
    chk({tag, ".ex_b"},      ex_b,               e.b);
    chk({tag, ".store"},     ex_store_data,      e.sd);
    chk({tag, ".alu"},       32'(ex_alucontrol), 32'(e.alu));
    chk({tag, ".rd"},        32'(ex_rd),         32'(e.rd));
    chk({tag, ".regwrite"},  32'(ex_regwrite),   32'(e.rw));
    chk({tag, ".memread"},   32'(ex_memread),    32'(e.mr));
    chk({tag, ".memwrite"},  32'(ex_memwrite),   32'(e.mw));
    chk({tag, ".memtoreg"},  32'(ex_memtoreg),   32'(e.mt));
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] data, input in_t x);
    if (FWD && idx != 0 && x.exrw && x.exrd == idx) return x.exres;
    if (FWD && idx != 0 && x.wbrw && x.wbrd == idx) return x.wbdata;
    return data;
  endfunction

  function automatic logic reads(input in_t x, input logic [4:0] r);
    return (r != 0) && (x.rs1 == r || x.rs2 == r);
  endfunction

  function automatic logic hz(input in_t x);
    logic h;
    h = x.idv && mv && mf.mr && reads(x, mf.rd);
    if (!FWD)
      h = h || (x.idv && ((mv && mf.rw && reads(x, mf.rd)) || (x.exrw && reads(x, x.exrd))));
    return h;
  endfunction

  function automatic exp_t mexp(input in_t x);
    exp_t e;
    e.stall = hz(x) && !x.flush;
    e.valid = mv;
    e.a     = mf.asel ? mf.pc  : fwd(mf.rs1, mf.d1, x);
    e.b     = mf.bsel ? mf.imm : fwd(mf.rs2, mf.d2, x);
    e.sd    = fwd(mf.rs2, mf.d2, x);
    e.alu   = mf.alu;
    e.rd    = mf.rd;
    e.rw    = mv && mf.rw;
    e.mr    = mv && mf.mr;
    e.mw    = mv && mf.mw;
    e.mt    = mv && mf.mt;
    return e;
  endfunction

  task automatic mstep(input in_t x);
    if (x.rst || x.flush || hz(x)) begin
      mv     = 1'b0;
      mf     = '0;
      mf.alu = ALU_ADD;
    end else begin
      mv = x.idv;
      mf = x;
    end
  endtask

  // ---------------- directed helpers ----------------
  function automatic in_t op(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [31:0] d1, input logic [4:0] rs2, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] alu,
                             input logic asel, input logic bsel, input logic rw, input logic mr,
                             input logic mw, input logic mt);
    in_t x = '0;
    x.idv = v; x.pc = pc; x.rs1 = rs1; x.d1 = d1; x.rs2 = rs2; x.d2 = d2; x.imm = imm;
    x.rd = rd; x.alu = alu; x.asel = asel; x.bsel = bsel;
    x.rw = rw; x.mr = mr; x.mw = mw; x.mt = mt;
    return x;
  endfunction

  function automatic in_t late(input in_t x, input logic exrw, input logic [4:0] exrd,
                               input logic [31:0] exres, input logic wbrw, input logic [4:0] wbrd,
                               input logic [31:0] wbdata);
    in_t y = x;
    y.exrw = exrw; y.exrd = exrd; y.exres = exres;
    y.wbrw = wbrw; y.wbrd = wbrd; y.wbdata = wbdata;
    return y;
  endfunction

  function automatic in_t with_rst(input in_t x);
    in_t y = x;
    y.rst = 1'b1;
    return y;
  endfunction

  function automatic in_t with_flush(input in_t x);
    in_t y = x;
    y.flush = 1'b1;
    return y;
  endfunction

  function automatic exp_t ex(input logic st, input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd, input logic [3:0] alu, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input logic mt);
    exp_t e;
    e.stall = st; e.valid = v; e.a = a; e.b = b; e.sd = sd; e.alu = alu; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.mt = mt;
    return e;
  endfunction

  function automatic vec_t V(input logic c, input in_t i, input exp_t e);
    vec_t v;
    v.chk = c; v.i = i; v.e = e;
    return v;
  endfunction

  initial begin
    vec_t q[$];
    in_t  idle, add58, x55, x77, lw, add6, auipc, sw, raw3, r;
    exp_t z, e_lw, e_add6;

    idle  = '0;
    add58 = op(1, 32'h0,   1, 32'd5,    2, 32'd7,  32'h0,    8,  ALU_ADD, 0, 0, 1, 0, 0, 0);
    x55   = op(0, 32'h0,   3, 32'h55,   0, 32'h66, 32'h0,    0,  ALU_SUB, 0, 0, 0, 0, 0, 0);
    x77   = op(0, 32'h0,   0, 32'h77,   0, 32'h66, 32'h0,    0,  ALU_SUB, 0, 0, 0, 0, 0, 0);
    lw    = op(1, 32'h40,  1, 32'h1000, 0, 32'h0,  32'h4,    6,  ALU_ADD, 0, 1, 1, 1, 0, 1);
    add6  = op(1, 32'h44,  5, 32'h11,   6, 32'h22, 32'h0,    7,  ALU_ADD, 0, 0, 1, 0, 0, 0);
    auipc = op(1, 32'h100, 0, 32'h0,    0, 32'h33, 32'h2000, 9,  ALU_ADD, 1, 1, 1, 0, 0, 0);
    sw    = op(1, 32'h104, 1, 32'h200,  2, 32'h44, 32'h8,    0,  ALU_ADD, 0, 1, 0, 0, 1, 0);
    raw3  = op(1, 32'h108, 3, 32'h12,   0, 32'h0,  32'h0,    10, ALU_ADD, 0, 0, 1, 0, 0, 0);

    z      = ex(0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0);
    e_lw   = ex(0, 1, 32'h1000, 32'h4, 32'h0, ALU_ADD, 6, 1, 1, 0, 1);
    e_add6 = ex(0, 1, 32'h11, FWD ? 32'hABCD : 32'h22, FWD ? 32'hABCD : 32'h22, ALU_ADD, 7, 1, 0, 0, 0);

    q.push_back(V(0, with_rst(idle), z));
    q.push_back(V(1, idle, z));                                         // reset values
    q.push_back(V(1, add58, z));
    q.push_back(V(1, idle, ex(0, 1, 5, 7, 7, ALU_ADD, 8, 1, 0, 0, 0))); // plain add
    q.push_back(V(1, x55, z));
    q.push_back(V(1, late(x55, 1, 3, 32'h10, 1, 3, 32'h20),
                  ex(0, 0, FWD ? 32'h10 : 32'h55, 32'h66, 32'h66, ALU_SUB, 0, 0, 0, 0, 0)));
    q.push_back(V(1, late(x77, 1, 4, 32'h10, 1, 3, 32'h20),
                  ex(0, 0, FWD ? 32'h20 : 32'h55, 32'h66, 32'h66, ALU_SUB, 0, 0, 0, 0, 0)));
    q.push_back(V(1, late(idle, 1, 0, 32'h10, 1, 0, 32'h20),
                  ex(0, 0, 32'h77, 32'h66, 32'h66, ALU_SUB, 0, 0, 0, 0, 0)));
    q.push_back(V(1, lw, z));
    e_lw.stall = 1'b1;
    q.push_back(V(1, add6, e_lw));                                      // load-use stall
    q.push_back(V(1, add6, z));                                         // bubble
    q.push_back(V(1, late(idle, 0, 0, 0, 1, 6, 32'hABCD), e_add6));     // memwb forward
    q.push_back(V(1, lw, z));
    e_lw.stall = 1'b0;
    q.push_back(V(1, with_flush(add6), e_lw));                          // flush masks stall
    q.push_back(V(1, idle, z));
    q.push_back(V(1, auipc, z));
    q.push_back(V(1, sw, ex(0, 1, 32'h100, 32'h2000, 32'h33, ALU_ADD, 9, 1, 0, 0, 0)));
    q.push_back(V(1, late(idle, 0, 0, 0, 1, 2, 32'h99),
                  ex(0, 1, 32'h200, 32'h8, FWD ? 32'h99 : 32'h44, ALU_ADD, 0, 0, 0, 1, 0)));
    q.push_back(V(1, lw, z));
    e_lw.stall = 1'b1;
    q.push_back(V(1, with_rst(add6), e_lw));                            // reset mid-stall
    q.push_back(V(1, add6, z));
    e_add6 = ex(!FWD, 1, 32'h11, 32'h22, 32'h22, ALU_ADD, 7, 1, 0, 0, 0);
    q.push_back(V(1, late(raw3, 1, 3, 32'h10, 0, 0, 0), e_add6));       // EX/MEM RAW
    q.push_back(V(1, idle, FWD ? ex(0, 1, 32'h12, 0, 0, ALU_ADD, 10, 1, 0, 0, 0) : z));

    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      cur = q[k].i;
      #1;
      if (q[k].chk) cmp_all($sformatf("dir%0d", k), q[k].e);
      @(posedge clk);
      mstep(cur);
    end

    for (int k = 0; k < 400; k++) begin
      r        = '0;
      r.rst    = (k == 0) || ($urandom_range(0, 39) == 0);
      r.flush  = ($urandom_range(0, 7) == 0);
      r.idv    = ($urandom_range(0, 3) != 0);
      r.pc     = $urandom; r.d1 = $urandom; r.d2 = $urandom; r.imm = $urandom;
      r.rs1    = 5'($urandom_range(0, 3));
      r.rs2    = 5'($urandom_range(0, 3));
      r.rd     = 5'($urandom_range(0, 3));
      r.alu    = 4'($urandom_range(0, 9));
      r.asel   = 1'($urandom); r.bsel = 1'($urandom);
      r.rw     = 1'($urandom); r.mr = 1'($urandom);
      r.mw     = 1'($urandom); r.mt = 1'($urandom);
      r.exrw   = 1'($urandom); r.exrd = 5'($urandom_range(0, 3)); r.exres = $urandom;
      r.wbrw   = 1'($urandom); r.wbrd = 5'($urandom_range(0, 3)); r.wbdata = $urandom;
      @(negedge clk);
      cur = r;
      #1;
      if (k > 0) begin
        cmp_all($sformatf("rnd%0d", k), mexp(cur));
        chk($sformatf("rnd%0d.ex_pc", k), ex_pc, mf.pc);
      end
      @(posedge clk);
      mstep(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
